wb_timer: RTL

//  Multi-channel Wishbone timer slave; replaces the ad-hoc free-running counter on main NIC slot 2.

---
 rtl/timer_pkg.sv | 41 ++++
 rtl/timer_channel.sv | 79 +++++++
 rtl/wb_timer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the Wishbone timer: register word offsets, channel layout, byte-lane helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package timer_pkg;

    // Word addresses (byte offset >> 2) of the global registers.
    localparam logic [5:0] ADR_CTRL     = 6'h00;
    localparam logic [5:0] ADR_PRESC    = 6'h01;
    localparam logic [5:0] ADR_CNT_LO   = 6'h02;
    localparam logic [5:0] ADR_CNT_HI   = 6'h03;
    localparam logic [5:0] ADR_IRQ_STAT = 6'h04;
    localparam logic [5:0] ADR_IRQ_EN   = 6'h05;
    localparam logic [5:0] ADR_CH_BASE  = 6'h08;

    // Each channel occupies a 0x10-byte window (four words).
    localparam int CH_STRIDE = 'h10;

    // Word offsets inside a channel window.
    localparam logic [1:0] CH_CMP_LO = 2'd0;
    localparam logic [1:0] CH_CMP_HI = 2'd1;
    localparam logic [1:0] CH_PERIOD = 2'd2;
    localparam logic [1:0] CH_CTRL   = 2'd3;

    typedef struct packed {
        logic periodic;
        logic en;
    } ch_ctrl_t;

    // Expand 4 byte-lane selects into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    // Replace only the selected bytes of old_val with new_val.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One compare channel: holds CMP, PERIOD and CTRL, pulses o_match when the ticking counter reaches CMP.
// Latency: o_match is combinational in the tick cycle; register updates land on the same edge as the counter.
// Backpressure: none; bus write strobes are single-cycle and always accepted.
// Ports: i_tick/i_next_cnt from the counter, per-register write strobes + data/mask, readback words, o_match.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_tick,
    input  logic [CNT_WIDTH-1:0] i_next_cnt,
    input  logic                 i_cmp_lo_we,
    input  logic                 i_cmp_hi_we,
    input  logic                 i_period_we,
    input  logic                 i_ctrl_we,
    input  logic [31:0]          i_wdat,
    input  logic [31:0]          i_wmask,
    output logic                 o_match,
    output logic [31:0]          o_cmp_lo,
    output logic [31:0]          o_cmp_hi,
    output logic [31:0]          o_period,
    output logic [31:0]          o_ctrl
);

    logic [CNT_WIDTH-1:0] cmp_q, cmp_d;
    logic [31:0]          period_q, period_d;
    ch_ctrl_t             ctrl_q, ctrl_d;
    logic [63:0]          cmp_ext;

    always_comb begin
        cmp_ext  = 64'(cmp_q);
        o_match  = i_tick && ctrl_q.en && (i_next_cnt == cmp_q);
        cmp_d    = cmp_q;
        period_d = period_q;
        ctrl_d   = ctrl_q;

        if (o_match) begin
            if (ctrl_q.periodic) begin
                cmp_d = cmp_q + CNT_WIDTH'(period_q);
            end else begin
                ctrl_d.en = 1'b0;
            end
        end

        // Bus writes come last so they override the match side effects.
        if (i_cmp_lo_we) begin
            cmp_d = CNT_WIDTH'({cmp_ext[63:32], merge_bytes(cmp_ext[31:0], i_wdat, i_wmask)});
        end
        if (i_cmp_hi_we) begin
            cmp_d = CNT_WIDTH'({merge_bytes(cmp_ext[63:32], i_wdat, i_wmask), cmp_ext[31:0]});
        end
        if (i_period_we) begin
            period_d = merge_bytes(period_q, i_wdat, i_wmask);
        end
        if (i_ctrl_we) begin
            ctrl_d = ch_ctrl_t'(2'(merge_bytes(32'(ctrl_q), i_wdat, i_wmask)));
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cmp_q    <= '0;
            period_q <= '0;
            ctrl_q   <= '0;
        end else begin
            cmp_q    <= cmp_d;
            period_q <= period_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign o_cmp_lo = cmp_ext[31:0];
    assign o_cmp_hi = cmp_ext[63:32];
    assign o_period = period_q;
    assign o_ctrl   = {30'd0, ctrl_q};

endmodule

// File: rtl/wb_timer.sv
// Wishbone timer slave: prescaled up-counter with NUM_CH compare channels and a maskable interrupt.
// Latency: register writes commit on the access cycle; read data and ack are registered (1 cycle).
// Backpressure: none; every access is acked exactly one cycle later, forcing an idle cycle between acks.
// Ports: i_clk/i_reset, Wishbone slave (i_dev_sel, i_wb_*, o_wb_dat, o_wb_ack), o_irq to the core.
module wb_timer
    import timer_pkg::*;
#(
    parameter int CNT_WIDTH   = 64,
    parameter int PRESC_WIDTH = 16,
    parameter int NUM_CH      = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_dev_sel,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    input  logic [5:0]  i_wb_adr,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_dat,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_irq
);

    logic                   en_q, en_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic [PRESC_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [31:0]            shadow_q, shadow_d;
    logic [NUM_CH-1:0]      irq_stat_q, irq_stat_d;
    logic [NUM_CH-1:0]      irq_en_q, irq_en_d;
    logic                   irq_q, irq_d;
    logic                   ack_q, ack_d;
    logic [31:0]            dat_q, dat_d;

    logic                   access, wr, rd;
    logic                   tick, cnt_wr, cnt_tick;
    logic [31:0]            wmask, rdata;
    logic [CNT_WIDTH-1:0]   next_cnt;
    logic [63:0]            cnt_ext;
    logic [3:0]             ch_sel;
    logic                   ch_hit;
    logic [NUM_CH-1:0]      ch_wr, ch_match;
    logic [31:0]            ch_cmp_lo [NUM_CH];
    logic [31:0]            ch_cmp_hi [NUM_CH];
    logic [31:0]            ch_period [NUM_CH];
    logic [31:0]            ch_ctrl   [NUM_CH];

    // The !ack term makes back-to-back cycles take two clocks each.
    assign access   = i_dev_sel && i_wb_cyc && !ack_q;
    assign wr       = access && i_wb_we;
    assign rd       = access && !i_wb_we;
    assign wmask    = lane_mask(i_wb_sel);
    assign cnt_ext  = 64'(cnt_q);
    assign next_cnt = cnt_q + CNT_WIDTH'(1);
    assign tick     = en_q && (presc_cnt_q == '0);
    assign cnt_wr   = wr && ((i_wb_adr == ADR_CNT_LO) || (i_wb_adr == ADR_CNT_HI));
    // A counter write replaces the increment, so that tick produces no match either.
    assign cnt_tick = tick && !cnt_wr;
    assign ch_sel   = i_wb_adr[5:2] - 4'd2;
    assign ch_hit   = (i_wb_adr >= ADR_CH_BASE) && (ch_sel < 4'(NUM_CH));

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        assign ch_wr[n] = wr && ch_hit && (ch_sel == 4'(n));

        timer_channel #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_ch (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .i_tick      (cnt_tick),
            .i_next_cnt  (next_cnt),
            .i_cmp_lo_we (ch_wr[n] && (i_wb_adr[1:0] == CH_CMP_LO)),
            .i_cmp_hi_we (ch_wr[n] && (i_wb_adr[1:0] == CH_CMP_HI)),
            .i_period_we (ch_wr[n] && (i_wb_adr[1:0] == CH_PERIOD)),
            .i_ctrl_we   (ch_wr[n] && (i_wb_adr[1:0] == CH_CTRL)),
            .i_wdat      (i_wb_dat),
            .i_wmask     (wmask),
            .o_match     (ch_match[n]),
            .o_cmp_lo    (ch_cmp_lo[n]),
            .o_cmp_hi    (ch_cmp_hi[n]),
            .o_period    (ch_period[n]),
            .o_ctrl      (ch_ctrl[n])
        );
    end

    // Read mux
    always_comb begin
        rdata = '0;
        case (i_wb_adr)
            ADR_CTRL:     rdata = {31'd0, en_q};
            ADR_PRESC:    rdata = 32'(presc_q);
            ADR_CNT_LO:   rdata = cnt_ext[31:0];
            ADR_CNT_HI:   rdata = shadow_q;
            ADR_IRQ_STAT: rdata = 32'(irq_stat_q);
            ADR_IRQ_EN:   rdata = 32'(irq_en_q);
            default: begin
                for (int n = 0; n < NUM_CH; n++) begin
                    if (ch_hit && (ch_sel == 4'(n))) begin
                        case (i_wb_adr[1:0])
                            CH_CMP_LO: rdata = ch_cmp_lo[n];
                            CH_CMP_HI: rdata = ch_cmp_hi[n];
                            CH_PERIOD: rdata = ch_period[n];
                            default:   rdata = ch_ctrl[n];
                        endcase
                    end
                end
            end
        endcase
    end

    // Next-state
    always_comb begin
        en_d        = en_q;
        presc_d     = presc_q;
        presc_cnt_d = presc_cnt_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        irq_en_d    = irq_en_q;
        ack_d       = access;
        dat_d       = rd ? rdata : 32'd0;
        irq_d       = |(irq_stat_q & irq_en_q);

        if (en_q) begin
            presc_cnt_d = tick ? presc_q : presc_cnt_q - PRESC_WIDTH'(1);
        end
        if (cnt_tick) begin
            cnt_d = next_cnt;
        end

        // Hardware set wins over a same-cycle W1C.
        irq_stat_d = irq_stat_q | ch_match;
        if (wr && (i_wb_adr == ADR_IRQ_STAT)) begin
            irq_stat_d = (irq_stat_q & ~NUM_CH'(i_wb_dat & wmask)) | ch_match;
        end

        // Snapshot the upper half so a following CNT_HI read is coherent with this CNT_LO.
        if (rd && (i_wb_adr == ADR_CNT_LO)) begin
            shadow_d = cnt_ext[63:32];
        end

        if (wr) begin
            case (i_wb_adr)
                ADR_CTRL: begin
                    if (i_wb_sel[0]) begin
                        en_d = i_wb_dat[0];
                    end
                end
                ADR_PRESC: begin
                    presc_d     = PRESC_WIDTH'(merge_bytes(32'(presc_q), i_wb_dat, wmask));
                    presc_cnt_d = presc_d;
                end
                ADR_CNT_LO: cnt_d = CNT_WIDTH'({cnt_ext[63:32],
                                                merge_bytes(cnt_ext[31:0], i_wb_dat, wmask)});
                ADR_CNT_HI: cnt_d = CNT_WIDTH'({merge_bytes(cnt_ext[63:32], i_wb_dat, wmask),
                                                cnt_ext[31:0]});
                ADR_IRQ_EN: irq_en_d = NUM_CH'(merge_bytes(32'(irq_en_q), i_wb_dat, wmask));
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            en_q        <= 1'b0;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            cnt_q       <= '0;
            shadow_q    <= '0;
            irq_stat_q  <= '0;
            irq_en_q    <= '0;
            irq_q       <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
        end else begin
            en_q        <= en_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            irq_stat_q  <= irq_stat_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
        end
    end

    assign o_wb_dat = dat_q;
    assign o_wb_ack = ack_q;
    assign o_irq    = irq_q;

endmodule
